// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four frame-synchronised test patterns (bar, colour bars, checker, gradient).
// Define VGA_PATTERN_CURSOR_EN to add the iCurX/iCurY crosshair overlay.
module vga_pattern_gen #(
    parameter int COLOR_W    = 10,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 2,
    parameter bit SYNC_POL   = 1'b0,
    parameter int BAR_STEP   = 1,
    parameter int CHECK_LOG2 = 5
) (
    input  logic               iClk,
    input  logic               nRst,
    input  logic               iRun,
    input  logic [1:0]         iMode,
`ifdef VGA_PATTERN_CURSOR_EN
    input  logic [11:0]        iCurX,
    input  logic [11:0]        iCurY,
`endif
    output logic               oPixEn,
    output logic               oHS,
    output logic               oVS,
    output logic               oBlank,
    output logic [COLOR_W-1:0] oR,
    output logic [COLOR_W-1:0] oG,
    output logic [COLOR_W-1:0] oB,
    output logic [11:0]        oX,
    output logic [11:0]        oY,
    output logic               oFrameStart,
    output logic [11:0]        oBarPos
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] V_HALF   = 12'(V_ACTIVE / 2);
    localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [12:0] STEP13   = 13'(BAR_STEP);
    localparam logic [12:0] H_ACT13  = 13'(H_ACTIVE);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [11:0]        hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [11:0]        bar_q, bar_d, x_q, x_d, y_q, y_d;
    logic [1:0]         mode_q, mode_d;
    logic               pix_en_q, pix_en_d, fs_q, fs_d;
    logic               hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               strobe, frame_start, active, cursor_hit;
    logic [12:0]        bar_sum;
    logic [2:0]         col_idx;
    logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

    // Mode/bar for the pixel being emitted use the _d values so that the
    // frame-start pixel already reflects the newly latched frame settings.
    always_comb begin
        strobe      = (div_q == DIV_LAST);
        div_d       = strobe ? '0 : div_q + DIV_W'(1);
        frame_start = strobe && (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        if (strobe) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 12'd0;
                vcnt_d = (vcnt_q == V_LAST) ? 12'd0 : vcnt_q + 12'd1;
            end else begin
                hcnt_d = hcnt_q + 12'd1;
            end
        end
        mode_d  = frame_start ? iMode : mode_q;
        bar_sum = {1'b0, bar_q} + STEP13;
        bar_d   = bar_q;
        if (frame_start && iRun) begin
            bar_d = (bar_sum >= H_ACT13) ? 12'd0 : bar_sum[11:0];
        end
    end

`ifdef VGA_PATTERN_CURSOR_EN
    logic [11:0] curx_q, curx_d, cury_q, cury_d;

    always_comb begin
        curx_d     = frame_start ? iCurX : curx_q;
        cury_d     = frame_start ? iCurY : cury_q;
        cursor_hit = (hcnt_q == curx_d) || (vcnt_q == cury_d);
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            curx_q <= 12'd0;
            cury_q <= 12'd0;
        end else begin
            curx_q <= curx_d;
            cury_q <= cury_d;
        end
    end
`else
    assign cursor_hit = 1'b0;
`endif

    always_comb begin
        active  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        col_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hcnt_q >= 12'(k * (H_ACTIVE / 8))) col_idx = 3'(k);
        end
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        case (mode_d)
            2'd0: begin
                pix_r = (hcnt_q <= bar_d) ? '1 : '0;
                pix_b = ~pix_r;
                pix_g = (vcnt_q < V_HALF) ? '1 : '0;
            end
            2'd1: begin
                pix_r = {COLOR_W{~col_idx[1]}};
                pix_g = {COLOR_W{~col_idx[2]}};
                pix_b = {COLOR_W{~col_idx[0]}};
            end
            2'd2: begin
                pix_r = {COLOR_W{hcnt_q[CHECK_LOG2] ^ vcnt_q[CHECK_LOG2]}};
                pix_g = pix_r;
                pix_b = pix_r;
            end
            default: begin
                pix_r = COLOR_W'(hcnt_q);
                pix_g = COLOR_W'(vcnt_q);
            end
        endcase
        if (cursor_hit) begin
            pix_r = '1;
            pix_g = '1;
            pix_b = '1;
        end
    end

    always_comb begin
        pix_en_d = strobe;
        fs_d     = frame_start;
        x_d      = x_q;
        y_d      = y_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        blank_d  = blank_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        if (strobe) begin
            x_d     = hcnt_q;
            y_d     = vcnt_q;
            hs_d    = (hcnt_q >= HS_FIRST && hcnt_q <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
            vs_d    = (vcnt_q >= VS_FIRST && vcnt_q <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
            blank_d = active;
            r_d     = active ? pix_r : '0;
            g_d     = active ? pix_g : '0;
            b_d     = active ? pix_b : '0;
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            div_q    <= '0;
            hcnt_q   <= 12'd0;
            vcnt_q   <= 12'd0;
            bar_q    <= 12'd0;
            mode_q   <= 2'd0;
            pix_en_q <= 1'b0;
            fs_q     <= 1'b0;
            x_q      <= 12'd0;
            y_q      <= 12'd0;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
            blank_q  <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            bar_q    <= bar_d;
            mode_q   <= mode_d;
            pix_en_q <= pix_en_d;
            fs_q     <= fs_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            blank_q  <= blank_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign oPixEn      = pix_en_q;
    assign oFrameStart = fs_q;
    assign oHS         = hs_q;
    assign oVS         = vs_q;
    assign oBlank      = blank_q;
    assign oR          = r_q;
    assign oG          = g_q;
    assign oB          = b_q;
    assign oX          = x_q;
    assign oY          = y_q;
    assign oBarPos     = bar_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced 64x32 raster: per-cycle model comparison plus pinned literals.
module tb_vga_pattern_gen;
    localparam int CW = 10, HA = 64, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 32, VFP = 2, VSY = 2, VBP = 4;
    localparam int DIV = 2, STEP = 21, CL = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int LIMIT = 2 * HT * VT * DIV;
    localparam logic [CW-1:0] ONES = '1;
    localparam logic [CW-1:0] ZERO = '0;

    logic          iClk = 1'b0;
    logic          nRst, iRun;
    logic [1:0]    iMode;
    logic          oPixEn, oHS, oVS, oBlank, oFrameStart;
    logic [CW-1:0] oR, oG, oB;
    logic [11:0]   oX, oY, oBarPos;

    int n_vec = 0;
    int n_err = 0;

    always #5 iClk = ~iClk;

    vga_pattern_gen #(
        .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .CLK_DIV(DIV), .SYNC_POL(1'b0), .BAR_STEP(STEP), .CHECK_LOG2(CL)
    ) dut (
        .iClk(iClk), .nRst(nRst), .iRun(iRun), .iMode(iMode),
        .oPixEn(oPixEn), .oHS(oHS), .oVS(oVS), .oBlank(oBlank),
        .oR(oR), .oG(oG), .oB(oB), .oX(oX), .oY(oY),
        .oFrameStart(oFrameStart), .oBarPos(oBarPos)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference colour straight from the pattern rules; colour bars via a lookup table.
    function automatic logic [3*CW-1:0] ref_rgb(int h, int v, int mode, int bar);
        logic [2:0] c;
        int idx;
        logic t;
        if (h >= HA || v >= VA) return '0;
        c = 3'b000;
        case (mode)
            0: c = {h <= bar, v < VA / 2, h > bar};
            1: begin
                idx = h / (HA / 8);
                if (idx > 7) idx = 7;
                case (idx)
                    0: c = 3'b111;
                    1: c = 3'b110;
                    2: c = 3'b011;
                    3: c = 3'b010;
                    4: c = 3'b101;
                    5: c = 3'b100;
                    6: c = 3'b001;
                    default: c = 3'b000;
                endcase
            end
            2: begin
                t = ((((h >> CL) ^ (v >> CL)) & 1) != 0);
                c = {t, t, t};
            end
            default: return {CW'(h), CW'(v), ZERO};
        endcase
        return {c[2] ? ONES : ZERO, c[1] ? ONES : ZERO, c[0] ? ONES : ZERO};
    endfunction

    // Model: the n-th strobe after reset presents pixel n mod (HT*VT) in raster order.
    int m_k, m_mode, m_bar;
    logic e_pix, e_fs, e_hs, e_vs, e_blank;
    logic [11:0] e_x, e_y;
    logic [3*CW-1:0] e_rgb;

    initial begin
        logic [1:0] s_mode;
        logic s_run;
        int n, h, v;
        m_k = 0; m_mode = 0; m_bar = 0;
        forever begin
            @(posedge iClk);
            s_mode = iMode;
            s_run  = iRun;
            #1;
            if (!nRst) begin
                m_k = 0; m_mode = 0; m_bar = 0;
                e_pix = 0; e_fs = 0; e_hs = 1; e_vs = 1; e_blank = 0;
                e_x = 0; e_y = 0; e_rgb = '0;
            end else begin
                m_k++;
                e_pix = 0;
                e_fs  = 0;
                if (m_k % DIV == 0) begin
                    n = m_k / DIV - 1;
                    h = n % HT;
                    v = (n / HT) % VT;
                    if (h == 0 && v == 0) begin
                        e_fs = 1;
                        m_mode = s_mode;
                        if (s_run) m_bar = (m_bar + STEP >= HA) ? 0 : m_bar + STEP;
                    end
                    e_pix   = 1;
                    e_x     = 12'(h);
                    e_y     = 12'(v);
                    e_hs    = !(h >= HA + HFP && h < HA + HFP + HSY);
                    e_vs    = !(v >= VA + VFP && v < VA + VFP + VSY);
                    e_blank = (h < HA && v < VA);
                    e_rgb   = ref_rgb(h, v, m_mode, m_bar);
                end
            end
            chk("strobes", {oPixEn, oFrameStart, oHS, oVS, oBlank}, {e_pix, e_fs, e_hs, e_vs, e_blank});
            chk("coords", {oX, oY}, {e_x, e_y});
            chk("rgb", {oR, oG, oB}, e_rgb);
            chk("barpos", oBarPos, 12'(m_bar));
        end
    end

    task automatic wait_pix(input int x, input int y);
        int c = 0;
        do begin
            @(negedge iClk);
            c++;
        end while (!(oPixEn && oX == 12'(x) && oY == 12'(y)) && c < LIMIT);
        if (c >= LIMIT) chk("wait_pix_timeout", 1, 0);
    endtask

    task automatic wait_fs();
        int c = 0;
        do begin
            @(negedge iClk);
            c++;
        end while (!oFrameStart && c < LIMIT);
        if (!oFrameStart) chk("wait_fs_timeout", 1, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_xy"}, {oX, oY}, 24'd0);
        chk({tag, "_ctl"}, {oPixEn, oFrameStart, oHS, oVS, oBlank}, 5'b00110);
        chk({tag, "_rgb"}, {oR, oG, oB}, '0);
        chk({tag, "_bar"}, oBarPos, 12'd0);
    endtask

    initial begin
        int cyc, hs_lo, vs_lo, fs_cnt;
        bit switched;
        nRst = 1'b0; iRun = 1'b1; iMode = 2'd0;
        repeat (3) @(negedge iClk);
        chk_reset_vals("rst");
        nRst = 1'b1;
        @(negedge iClk);
        chk("first_pixen_early", oPixEn, 0);
        @(negedge iClk);
        chk("first_pixel", {oPixEn, oFrameStart, oX, oY}, {1'b1, 1'b1, 24'd0});
        chk("bar_f0", oBarPos, 12'd21);

        wait_pix(21, 10); chk("m0_on_bar", {oR, oG, oB}, {ONES, ONES, ZERO});
        wait_pix(22, 10); chk("m0_off_bar", {oR, oG, oB}, {ZERO, ONES, ONES});
        wait_pix(22, 20); chk("m0_low_half", {oR, oG, oB}, {ZERO, ZERO, ONES});
        iMode = 2'd1; iRun = 1'b0;

        wait_fs();
        chk("bar_hold", oBarPos, 12'd21);
        iRun = 1'b1;
        cyc = 0; hs_lo = 0; vs_lo = 0; fs_cnt = 0; switched = 0;
        do begin
            if (oFrameStart) fs_cnt++;
            if (oPixEn) begin
                if (!oHS) hs_lo++;
                if (!oVS) vs_lo++;
                if (oY == 12'd5) begin
                    case (oX)
                        12'd0:  chk("m1_white",  {oR, oG, oB}, {ONES, ONES, ONES});
                        12'd8:  chk("m1_yellow", {oR, oG, oB}, {ONES, ONES, ZERO});
                        12'd40: chk("m1_red",    {oR, oG, oB}, {ONES, ZERO, ZERO});
                        12'd63: chk("m1_black",  {oR, oG, oB}, '0);
                        12'd70: chk("m1_blank",  {oBlank, oR, oG, oB}, '0);
                        default: ;
                    endcase
                end
                if (oY == 12'd20 && !switched) begin
                    iMode = 2'd2;
                    switched = 1;
                end
                if (oY == 12'd25 && oX == 12'd40) chk("m1_held", {oR, oG, oB}, {ONES, ZERO, ZERO});
            end
            @(negedge iClk);
            cyc++;
        end while (!oFrameStart && cyc < LIMIT);
        chk("frame_clks", cyc, HT * VT * DIV);
        chk("hs_low", hs_lo, HSY * VT);
        chk("vs_low", vs_lo, VSY * HT);
        chk("fs_pulses", fs_cnt, 1);

        chk("bar_f2", oBarPos, 12'd42);
        chk("m2_origin", {oPixEn, oX, oY, oR, oG, oB}, {1'b1, 24'd0, 30'd0});
        wait_pix(8, 0); chk("m2_square", {oR, oG, oB}, {ONES, ONES, ONES});
        iMode = 2'd3;
        wait_fs(); chk("bar_f3", oBarPos, 12'd63);
        wait_fs(); chk("bar_wrap", oBarPos, 12'd0);

        for (int i = 0; i < 40; i++) begin
            iMode = 2'($urandom_range(0, 3));
            iRun  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(50, 600)) @(negedge iClk);
        end

        wait_pix(30, 3);
        nRst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (3) @(negedge iClk);
        nRst = 1'b1;
        @(negedge iClk);
        chk("restart_pixen_early", oPixEn, 0);
        @(negedge iClk);
        chk("restart_pixel", {oPixEn, oFrameStart, oX, oY}, {1'b1, 1'b1, 24'd0});
        repeat (1000) @(negedge iClk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
